program_loader: RTL and testbench

//  Writer side of the 16x8 instruction memory. The CPU fetch path only reads this memory.

---
 rtl/program_loader.sv | 82 ++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a byte stream, verifies it by checksum, then releases the CPU
module program_loader #(
  parameter int LOAD_LEN = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [DATA_W-1:0] ld_sum, rb_sum;
  logic accept, go, last_wr, last_rd, bad;
  // verify runs one cycle past the last address to collect the registered read data
  always_comb begin
    go        = start && (state == IDLE || state == DONE);
    in_ready  = state == LOAD;
    accept    = in_ready && in_valid;
    last_wr   = wr_cnt == ADDR_W'(LOAD_LEN - 1);
    last_rd   = rd_cnt == (ADDR_W + 1)'(LOAD_LEN);
    bad       = rb_sum != ld_sum;
    mem_write = accept;
    mem_wdata = in_ready ? in_data : '0;
    mem_addr  = in_ready ? wr_cnt :
                state == VERIFY ? (last_rd ? ADDR_W'(LOAD_LEN - 1) : rd_cnt[ADDR_W-1:0]) : '0;
    state_n   = go ? LOAD :
                (accept && last_wr) ? VERIFY :
                (state == VERIFY && last_rd) ? CHECK :
                state == CHECK ? DONE : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      ld_sum   <= '0;
      rb_sum   <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_n;
      if (go) begin
        wr_cnt   <= '0;
        ld_sum   <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (accept) begin
        wr_cnt <= last_wr ? wr_cnt : wr_cnt + 1'b1;
        ld_sum <= ld_sum + in_data;
        if (last_wr) begin
          rd_cnt <= '0;
          rb_sum <= '0;
        end
      end
      if (state == VERIFY) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt != '0) rb_sum <= rb_sum + mem_rdata;
      end
      if (state == CHECK) begin
        error    <= bad;
        done     <= 1'b1;
        cpu_hold <= bad;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader with a registered 16x8 memory model
module tb_program_loader;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST, start, in_valid, in_ready, mem_write, cpu_hold, done, error, corrupt, noise;
  logic [7:0] in_data, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;
  logic start4, valid4, ready4, write4, hold4, done4, err4;
  logic [7:0] data4, wdata4, rdata4;
  logic [3:0] addr4, max4;
  logic [7:0] mem [16];
  logic [7:0] m4 [16];
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0, w4_cnt = 0;

  program_loader dut (.CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .done(done), .error(error));
  program_loader #(.LOAD_LEN(4)) dut4 (.CLK(CLK), .RST(RST), .start(start4), .in_valid(valid4),
    .in_data(data4), .in_ready(ready4), .mem_addr(addr4), .mem_wdata(wdata4), .mem_write(write4),
    .mem_rdata(rdata4), .cpu_hold(hold4), .done(done4), .error(err4));

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr] ^ {7'b0, corrupt && mem_addr == 4'd5};
    if (write4) m4[addr4] <= wdata4;
    rdata4 <= m4[addr4];
  end

  typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic e; logic h; int c;} res_t;
  wr_t wq[$];
  res_t rq[$];
  wr_t w;
  res_t r;
  logic done_q = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mem_write) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {28'b0, mem_addr}, {28'b0, w.a});
        chk("wr_data", {24'b0, mem_wdata}, {24'b0, w.d});
      end
    end
    if (done && !done_q) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, required 0");
      end else begin
        r = rq.pop_front();
        chk("error", {31'b0, error}, {31'b0, r.e});
        chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, r.h});
        chk("done_cycle", cyc, r.c);
      end
    end
    done_q = done;
    if (write4) begin
      chk("u4_write_addr_lt4", {31'b0, addr4 < 4'd4}, 1);
      w4_cnt++;
    end
    if (addr4 > max4) max4 = addr4;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic v);
    start = 1'b1;
    in_valid = v;
    in_data = 8'h99;
    #1;
    chk("no_write_on_start", {31'b0, mem_write}, 0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] a, input int gap);
    wr_t e;
    repeat (gap) begin
      start = noise;
      chk("ready_in_gap", {31'b0, in_ready}, 1);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    e.a = a;
    e.d = d;
    wq.push_back(e);
    last_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required 1", n);
    end
  endtask

  // sends 16 bytes base+step*i; done expected 1 accept + 17 verify + 1 check cycles after the last byte is driven
  task automatic load_bytes(input logic [7:0] base, input logic [7:0] step, input int gap,
                            input logic e, input logic h);
    res_t x;
    for (int i = 0; i < 16; i++) send(base + 8'(i) * step, 4'(i), i > 0 ? gap : 0);
    x.e = e;
    x.h = h;
    x.c = last_cyc + 19;
    rq.push_back(x);
    wait_done();
  endtask

  task automatic chk_mem(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), {24'b0, mem[i]}, {24'b0, base + 8'(i) * step});
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; corrupt = 1'b0; noise = 1'b0;
    start4 = 1'b0; valid4 = 1'b0; data4 = 8'h00; max4 = 4'd0;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_mem_addr", {28'b0, mem_addr}, 0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 0);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    RST = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    #1;
    chk("idle_no_write", {31'b0, mem_write}, 0);
    chk("idle_no_ready", {31'b0, in_ready}, 0);
    tick();
    tick();
    in_valid = 1'b0;
    do_start(1'b1);
    load_bytes(8'h00, 8'h01, 0, 1'b0, 1'b0);
    chk_mem(8'h00, 8'h01);
    tick();
    chk("clean_release", {31'b0, cpu_hold}, 0);
    noise = 1'b1;
    do_start(1'b0);
    chk("start_clears_done", {31'b0, done}, 0);
    load_bytes(8'h00, 8'h01, 1, 1'b0, 1'b0);
    noise = 1'b0;
    chk_mem(8'h00, 8'h01);
    do_start(1'b0);
    load_bytes(8'hFF, 8'h00, 0, 1'b0, 1'b0);
    chk_mem(8'hFF, 8'h00);
    corrupt = 1'b1;
    do_start(1'b0);
    load_bytes(8'h00, 8'h01, 0, 1'b1, 1'b1);
    repeat (3) tick();
    chk("err_hold_stays", {31'b0, cpu_hold}, 1);
    chk("err_level", {31'b0, error}, 1);
    corrupt = 1'b0;
    do_start(1'b0);
    chk("restart_done", {31'b0, done}, 0);
    chk("restart_error", {31'b0, error}, 0);
    load_bytes(8'h00, 8'h01, 0, 1'b0, 1'b0);
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 4'(i), 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready}, 0);
    chk("midrst_cpu_hold", {31'b0, cpu_hold}, 1);
    chk("midrst_done", {31'b0, done}, 0);
    do_start(1'b0);
    load_bytes(8'h40, 8'h01, 0, 1'b0, 1'b0);
    chk_mem(8'h40, 8'h01);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid4 = 1'b1;
      data4 = 8'h10 + 8'(i);
      tick();
    end
    valid4 = 1'b0;
    for (int n = 0; n < 20 && !done4; n++) tick();
    chk("u4_done", {31'b0, done4}, 1);
    chk("u4_error", {31'b0, err4}, 0);
    chk("u4_hold", {31'b0, hold4}, 0);
    chk("u4_writes", w4_cnt, 4);
    chk("u4_max_addr", {28'b0, max4}, 3);
    for (int i = 0; i < 4; i++) chk($sformatf("m4[%0d]", i), {24'b0, m4[i]}, {24'b0, 8'h10 + 8'(i)});
    tick();
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
